// File: rtl/pipe_flow_ctrl_if.sv
// pipe_flow_ctrl_if: hazard/flow controller signal bundle between pipeline (master) and controller (slave)
interface pipe_flow_ctrl_if #(
    parameter int CPU_WIDTH = 32
);
    logic                 trap_req_i;
    logic [CPU_WIDTH-1:0] trap_cause_i;
    logic [CPU_WIDTH-1:0] mem_pc_i;
    logic [CPU_WIDTH-1:0] mtvec_i;
    logic [CPU_WIDTH-1:0] mstatus_i;
    logic [CPU_WIDTH-1:0] mepc_i;
    logic                 mem_req_i;
    logic                 mem_ready_i;
    logic                 div_busy_i;
    logic                 jump_en_i;
    logic [CPU_WIDTH-1:0] jump_addr_i;
    logic                 mret_i;
    logic                 load_use_i;
    logic [1:0]           flow_pc_o;
    logic [1:0]           flow_id_o;
    logic [1:0]           flow_ex_o;
    logic [1:0]           flow_mem_o;
    logic [1:0]           flow_wb_o;
    logic                 redirect_en_o;
    logic [CPU_WIDTH-1:0] redirect_addr_o;
    logic                 csr_wr_en_o;
    logic [11:0]          csr_wr_adder_o;
    logic [CPU_WIDTH-1:0] csr_wr_data_o;
    logic                 mem_abort_o;
    logic                 trap_busy_o;

    modport master (
        output trap_req_i, trap_cause_i, mem_pc_i, mtvec_i, mstatus_i, mepc_i,
               mem_req_i, mem_ready_i, div_busy_i, jump_en_i, jump_addr_i, mret_i, load_use_i,
        input  flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o, flow_wb_o, redirect_en_o,
               redirect_addr_o, csr_wr_en_o, csr_wr_adder_o, csr_wr_data_o, mem_abort_o, trap_busy_o
    );

    modport slave (
        input  trap_req_i, trap_cause_i, mem_pc_i, mtvec_i, mstatus_i, mepc_i,
               mem_req_i, mem_ready_i, div_busy_i, jump_en_i, jump_addr_i, mret_i, load_use_i,
        output flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o, flow_wb_o, redirect_en_o,
               redirect_addr_o, csr_wr_en_o, csr_wr_adder_o, csr_wr_data_o, mem_abort_o, trap_busy_o
    );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: pipeline hazard arbiter and multi-cycle trap-entry sequencer
module pipe_flow_ctrl #(
    parameter int CPU_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input logic clk,
    input logic rst_n,
    pipe_flow_ctrl_if.slave bus
);
    localparam logic [1:0] WORK = 2'b00, STOP = 2'b01, REFRESH = 2'b10;
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, TRAP_MEPC, TRAP_MCAUSE, TRAP_MSTATUS, TRAP_JUMP} state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [CPU_WIDTH-1:0] cause_q, cause_d, pc_q, pc_d, mtvec_q, mtvec_d, mstatus_q, mstatus_d;
    logic [1:0]           f_pc, f_id, f_ex, f_mem, f_wb;
    logic                 stalled, timeout;
    logic [CPU_WIDTH-1:0] mret_ms, trap_ms;

    assign stalled = bus.mem_req_i & ~bus.mem_ready_i;
    assign timeout = stalled && cnt_q == TMO_LAST;

    always_comb begin
        mret_ms     = bus.mstatus_i;
        mret_ms[3]  = bus.mstatus_i[7];
        mret_ms[7]  = 1'b1;
        trap_ms     = mstatus_q;
        trap_ms[7]  = mstatus_q[3];
        trap_ms[3]  = 1'b0;
        trap_ms[12:11] = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cause_q   <= '0;
            pc_q      <= '0;
            mtvec_q   <= '0;
            mstatus_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            pc_q      <= pc_d;
            mtvec_q   <= mtvec_d;
            mstatus_q <= mstatus_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        cause_d   = cause_q;
        pc_d      = pc_q;
        mtvec_d   = mtvec_q;
        mstatus_d = mstatus_q;
        f_pc  = (state_q == IDLE) ? WORK : STOP;
        f_id  = (state_q == IDLE) ? WORK : REFRESH;
        f_ex  = f_id;
        f_mem = f_id;
        f_wb  = f_id;
        bus.redirect_en_o   = 1'b0;
        bus.redirect_addr_o = '0;
        bus.csr_wr_en_o     = 1'b0;
        bus.csr_wr_adder_o  = '0;
        bus.csr_wr_data_o   = '0;
        bus.mem_abort_o     = 1'b0;
        bus.trap_busy_o     = state_q != IDLE;
        case (state_q)
            IDLE: begin
                if (bus.trap_req_i || timeout) begin
                    {f_pc, f_id, f_ex, f_mem, f_wb} = {STOP, REFRESH, REFRESH, REFRESH, REFRESH};
                    bus.mem_abort_o = timeout;
                    cause_d   = bus.trap_req_i ? bus.trap_cause_i : CPU_WIDTH'(5);
                    pc_d      = bus.mem_pc_i;
                    mtvec_d   = bus.mtvec_i;
                    mstatus_d = bus.mstatus_i;
                    state_d   = TRAP_MEPC;
                end else if (stalled) begin
                    {f_pc, f_id, f_ex, f_mem, f_wb} = {STOP, STOP, STOP, STOP, REFRESH};
                    cnt_d = cnt_q + 8'd1;
                end else if (bus.div_busy_i) begin
                    {f_pc, f_id, f_ex, f_mem} = {STOP, STOP, STOP, REFRESH};
                end else if (bus.mret_i) begin
                    {f_id, f_ex} = {REFRESH, REFRESH};
                    bus.redirect_en_o   = 1'b1;
                    bus.redirect_addr_o = bus.mepc_i;
                    bus.csr_wr_en_o     = 1'b1;
                    bus.csr_wr_adder_o  = 12'h300;
                    bus.csr_wr_data_o   = mret_ms;
                end else if (bus.jump_en_i) begin
                    {f_id, f_ex} = {REFRESH, REFRESH};
                    bus.redirect_en_o   = 1'b1;
                    bus.redirect_addr_o = bus.jump_addr_i;
                end else if (bus.load_use_i) begin
                    {f_pc, f_id, f_ex} = {STOP, STOP, REFRESH};
                end
            end
            TRAP_MEPC: begin
                bus.csr_wr_en_o    = 1'b1;
                bus.csr_wr_adder_o = 12'h341;
                bus.csr_wr_data_o  = pc_q;
                state_d = TRAP_MCAUSE;
            end
            TRAP_MCAUSE: begin
                bus.csr_wr_en_o    = 1'b1;
                bus.csr_wr_adder_o = 12'h342;
                bus.csr_wr_data_o  = cause_q;
                state_d = TRAP_MSTATUS;
            end
            TRAP_MSTATUS: begin
                bus.csr_wr_en_o    = 1'b1;
                bus.csr_wr_adder_o = 12'h300;
                bus.csr_wr_data_o  = trap_ms;
                state_d = TRAP_JUMP;
            end
            TRAP_JUMP: begin
                f_pc = WORK;
                bus.redirect_en_o   = 1'b1;
                bus.redirect_addr_o = mtvec_q & ~CPU_WIDTH'(3);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        bus.flow_pc_o  = f_pc;
        bus.flow_id_o  = f_id;
        bus.flow_ex_o  = f_ex;
        bus.flow_mem_o = f_mem;
        bus.flow_wb_o  = f_wb;
    end
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb_pipe_flow_ctrl: randomized scoreboard bench with a rule-level reference model
module tb_pipe_flow_ctrl;
    localparam int MT = 16;

    typedef struct packed {
        logic [1:0]  pc, id, ex, mem, wb;
        logic        rd_en;
        logic [31:0] rd_addr;
        logic        csr_en;
        logic [11:0] csr_addr;
        logic [31:0] csr_data;
        logic        abort, busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_flow_ctrl_if #(.CPU_WIDTH(32)) bus ();
    pipe_flow_ctrl #(.CPU_WIDTH(32), .MEM_TIMEOUT(MT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t sbq[$];
    exp_t pend[$];
    int   stall_run = 0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    task automatic drive_idle();
        bus.trap_req_i = 0; bus.mem_req_i = 0; bus.mem_ready_i = 0; bus.div_busy_i = 0;
        bus.jump_en_i = 0; bus.mret_i = 0; bus.load_use_i = 0;
        bus.trap_cause_i = 0; bus.mem_pc_i = 0; bus.mtvec_i = 0; bus.mstatus_i = 0;
        bus.mepc_i = 0; bus.jump_addr_i = 0;
    endtask

    task automatic drive_rand();
        bus.trap_req_i  = ($urandom % 20) == 0;
        bus.mem_req_i   = ($urandom % 3) == 0;
        bus.mem_ready_i = $urandom % 2;
        bus.div_busy_i  = ($urandom % 6) == 0;
        bus.jump_en_i   = ($urandom % 5) == 0;
        bus.mret_i      = ($urandom % 8) == 0;
        bus.load_use_i  = ($urandom % 4) == 0;
        bus.trap_cause_i = $urandom; bus.mem_pc_i = $urandom; bus.mtvec_i = $urandom;
        bus.mstatus_i = $urandom; bus.mepc_i = $urandom; bus.jump_addr_i = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected response for the inputs currently driven; a trap queues its whole CSR/redirect script.
    task automatic model();
        exp_t e, s;
        logic st, to;
        logic [31:0] d;
        e = '0;
        if (!rst_n) begin
            pend.delete();
            stall_run = 0;
        end else if (pend.size() > 0) begin
            e = pend.pop_front();
            stall_run = 0;
        end else begin
            st = bus.mem_req_i && !bus.mem_ready_i;
            to = st && stall_run == MT - 1;
            if (bus.trap_req_i || to) begin
                e.pc = 1; e.id = 2; e.ex = 2; e.mem = 2; e.wb = 2; e.abort = to;
                s = e; s.abort = 0; s.busy = 1; s.csr_en = 1;
                s.csr_addr = 12'h341; s.csr_data = bus.mem_pc_i; pend.push_back(s);
                s.csr_addr = 12'h342; s.csr_data = bus.trap_req_i ? bus.trap_cause_i : 32'd5; pend.push_back(s);
                d = bus.mstatus_i; d[7] = d[3]; d[3] = 0; d[12:11] = 2'b11;
                s.csr_addr = 12'h300; s.csr_data = d; pend.push_back(s);
                s = '0; s.busy = 1; s.id = 2; s.ex = 2; s.mem = 2; s.wb = 2;
                s.rd_en = 1; s.rd_addr = {bus.mtvec_i[31:2], 2'b00}; pend.push_back(s);
                stall_run = 0;
            end else if (st) begin
                e.pc = 1; e.id = 1; e.ex = 1; e.mem = 1; e.wb = 2;
                stall_run++;
            end else begin
                stall_run = 0;
                if (bus.div_busy_i) begin
                    e.pc = 1; e.id = 1; e.ex = 1; e.mem = 2;
                end else if (bus.mret_i) begin
                    e.id = 2; e.ex = 2; e.rd_en = 1; e.rd_addr = bus.mepc_i;
                    d = bus.mstatus_i; d[3] = d[7]; d[7] = 1;
                    e.csr_en = 1; e.csr_addr = 12'h300; e.csr_data = d;
                end else if (bus.jump_en_i) begin
                    e.id = 2; e.ex = 2; e.rd_en = 1; e.rd_addr = bus.jump_addr_i;
                end else if (bus.load_use_i) begin
                    e.pc = 1; e.id = 1; e.ex = 2;
                end
            end
        end
        sbq.push_back(e);
    endtask

    task automatic step_idle(int n);
        repeat (n) begin tick(); drive_idle(); model(); end
    endtask

    task automatic step_rand(int n);
        repeat (n) begin tick(); drive_rand(); model(); end
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(negedge clk);
            cyc++;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                a = '0;
                a.pc = bus.flow_pc_o; a.id = bus.flow_id_o; a.ex = bus.flow_ex_o;
                a.mem = bus.flow_mem_o; a.wb = bus.flow_wb_o;
                a.rd_en = bus.redirect_en_o; a.rd_addr = e.rd_en ? bus.redirect_addr_o : 32'd0;
                a.csr_en = bus.csr_wr_en_o;
                a.csr_addr = e.csr_en ? bus.csr_wr_adder_o : 12'd0;
                a.csr_data = e.csr_en ? bus.csr_wr_data_o : 32'd0;
                a.abort = bus.mem_abort_o; a.busy = bus.trap_busy_o;
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL cycle%0d outputs: got %p want %p", cyc, a, e);
                end
            end
        end
    end

    initial begin
        drive_idle();
        step_idle(3);
        tick(); rst_n = 1; drive_idle(); model();
        step_idle(10);
        tick(); drive_idle(); bus.load_use_i = 1; model();
        tick(); drive_idle(); bus.load_use_i = 1; bus.jump_en_i = 1; bus.jump_addr_i = 32'h80; model();
        repeat (3) begin tick(); drive_idle(); bus.mem_req_i = 1; bus.div_busy_i = 1; model(); end
        tick(); drive_idle(); bus.mem_req_i = 1; bus.mem_ready_i = 1; model();
        tick(); drive_idle(); bus.trap_req_i = 1; bus.trap_cause_i = 2; bus.mem_pc_i = 32'h1000;
        bus.mtvec_i = 32'h2001; bus.mstatus_i = 32'h8; model();
        step_rand(4);
        step_idle(2);
        for (int i = 0; i < MT; i++) begin
            tick(); drive_idle(); bus.mem_req_i = 1; bus.mem_pc_i = 32'h3000;
            bus.mtvec_i = 32'h4000; model();
        end
        step_idle(6);
        tick(); drive_idle(); bus.trap_req_i = 1; bus.trap_cause_i = 7; bus.mem_pc_i = 32'h500;
        bus.mtvec_i = 32'h600; model();
        step_idle(1);
        tick(); rst_n = 0; drive_idle(); model();
        tick(); rst_n = 1; drive_idle(); model();
        step_idle(5);
        step_rand(400);
        step_idle(3);
        tick();
        tick();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
